// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and small helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [3:0]  OPC_HLT   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_INC    = 16'd2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    BUF  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == OPC_HLT;
  endfunction

  // Instructions are halfword aligned; bit 0 of any target is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory / I-cache request bus between the fetch stage and memory.
interface fetch_if;
  import fetch_pkg::*;

  logic [15:0] addr;
  logic        req;
  logic [15:0] rdata;
  logic        valid;

  modport master (output addr, req, input rdata, valid);
  modport slave  (input addr, req, output rdata, valid);

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter flop with load enable and synchronous reset to RESET_PC.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [15:0] pc_next,
  output logic [15:0] pc
);

  logic [15:0] pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (wen) begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, talks to the instruction memory and writes the F/D register,
// handling stalls, decode redirects, cache misses and HLT.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_if.master       imem,
  input  logic          fd_stall,
  input  logic          br_taken,
  input  logic [15:0]   br_target,
  output logic [15:0]   fd_instr,
  output logic [15:0]   fd_oldpc,
  output logic [15:0]   fd_newpc,
  output logic          fd_wen,
  output logic          halted
);

  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_MISS = 2'(MISS);
  localparam logic [1:0] ST_BUF  = 2'(BUF);
  localparam logic [1:0] ST_HALT = 2'(HALT);

  logic [1:0]  state_reg, state_next;
  logic [15:0] ibuf_reg;
  logic        ibuf_wen;
  logic        redir_pend_reg;
  logic [15:0] redir_tgt_reg;
  logic        redir_set, redir_clr;

  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        pc_wen;
  logic [15:0] br_tgt;
  logic [15:0] deliver_word;
  logic        deliver;

  assign br_tgt = align_pc(br_target);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .wen     (pc_wen),
    .pc_next (pc_next),
    .pc      (pc)
  );

  always_comb begin
    state_next   = state_reg;
    pc_wen       = 1'b0;
    pc_next      = pc;
    ibuf_wen     = 1'b0;
    redir_set    = 1'b0;
    redir_clr    = 1'b0;
    deliver      = 1'b0;
    deliver_word = (state_reg == ST_BUF) ? ibuf_reg : imem.rdata;

    imem.req  = 1'b0;
    imem.addr = pc;
    fd_wen    = 1'b0;
    fd_instr  = NOP_INSTR;
    fd_oldpc  = pc;
    fd_newpc  = pc;
    halted    = 1'b0;

    case (state_reg)
      ST_RUN: begin
        imem.req = 1'b1;
        if (br_taken) begin
          fd_wen  = 1'b1;
          pc_wen  = 1'b1;
          pc_next = br_tgt;
        end else if (fd_stall) begin
          // The returned word (if any) is dropped and refetched once the stall clears.
          if (!imem.valid) begin
            state_next = ST_MISS;
          end
        end else if (!imem.valid) begin
          fd_wen     = 1'b1;
          state_next = ST_MISS;
        end else begin
          deliver = 1'b1;
        end
      end

      ST_MISS: begin
        imem.req = 1'b1;
        redir_set = br_taken;
        if (imem.valid) begin
          if (redir_pend_reg || br_taken) begin
            // A redirect that arrived mid-miss only takes effect once the memory has answered.
            fd_wen     = 1'b1;
            pc_wen     = 1'b1;
            pc_next    = br_taken ? br_tgt : redir_tgt_reg;
            redir_clr  = 1'b1;
            state_next = ST_RUN;
          end else if (fd_stall) begin
            ibuf_wen   = 1'b1;
            state_next = ST_BUF;
          end else begin
            deliver = 1'b1;
          end
        end else begin
          fd_wen = br_taken | ~fd_stall;
        end
      end

      ST_BUF: begin
        if (br_taken) begin
          fd_wen     = 1'b1;
          pc_wen     = 1'b1;
          pc_next    = br_tgt;
          state_next = ST_RUN;
        end else if (!fd_stall) begin
          deliver = 1'b1;
        end
      end

      default: begin
        fd_wen = 1'b1;
        halted = 1'b1;
      end
    endcase

    if (deliver) begin
      fd_wen   = 1'b1;
      fd_instr = deliver_word;
      fd_oldpc = pc;
      fd_newpc = pc + PC_INC;
      if (is_hlt(deliver_word)) begin
        state_next = ST_HALT;
      end else begin
        pc_wen     = 1'b1;
        pc_next    = pc + PC_INC;
        state_next = ST_RUN;
      end
    end

    if (rst) begin
      imem.req  = 1'b0;
      imem.addr = RESET_PC;
      fd_wen    = 1'b0;
      fd_instr  = NOP_INSTR;
      fd_oldpc  = RESET_PC;
      fd_newpc  = RESET_PC;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      ibuf_reg  <= NOP_INSTR;
    end else begin
      state_reg <= state_next;
      if (ibuf_wen) begin
        ibuf_reg <= imem.rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_pend_reg <= 1'b0;
      redir_tgt_reg  <= 16'h0000;
    end else if (redir_clr) begin
      redir_pend_reg <= 1'b0;
    end else if (redir_set) begin
      redir_pend_reg <= 1'b1;
      redir_tgt_reg  <= br_tgt;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage 16-bit pipeline. It owns the PC, requests instructions from the instruction memory/I-cache, and drives the write side of the F/D pipeline register (instruction, old PC, new PC, write enable). It handles hazard-unit stalls, decode-stage branch redirects, I-cache misses, and HLT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- imem_addr  out  16  fetch address; equals PC in RUN/MISS.
- imem_req  out  1  fetch request; high in RUN and MISS.
- imem_rdata  in  16  instruction word; valid only when imem_valid=1.
- imem_valid  in  1  rdata valid; same cycle on hit, later on miss.
- fd_stall  in  1  hazard unit holds the F/D register and PC.
- br_taken  in  1  decode resolved a taken branch this cycle.
- br_target  in  16  branch target; qualified by br_taken.
- fd_instr  out  16  instruction to F/D register.
- fd_oldpc  out  16  address of fd_instr.
- fd_newpc  out  16  fd_oldpc + 2.
- fd_wen  out  1  F/D register write enable.
- halted  out  1  HLT fetched; fetch frozen.

## Operation
- States: RUN, MISS, BUF, HALT.
- Bubble means fd_instr=NOP_INSTR (16'h0000), fd_oldpc=fd_newpc=PC, fd_wen=1.
- RUN:
  - imem_valid=1, no stall, no redirect: fd_instr=imem_rdata, fd_oldpc=PC, fd_newpc=PC+2, fd_wen=1, PC<=PC+2.
  - If rdata[15:12]==OPC_HLT: PC holds, HLT is forwarded, next state is HALT.
  - imem_valid=0: issue a bubble (or fd_wen=0 if stalled); next state is MISS; PC and imem_addr hold.
- MISS:
  - imem_addr stays at PC until imem_valid; the address must not change mid-miss.
  - On valid with no stall: deliver as in RUN; next state is RUN.
  - On valid with fd_stall=1: capture the word into ibuf; next state is BUF.
- BUF:
  - imem_req=0.
  - While fd_stall=1: fd_wen=0.
  - When fd_stall drops: present ibuf exactly as RUN would present rdata; next state is RUN (or HALT if ibuf is HLT).
- HALT:
  - imem_req=0, fd_wen=1 with bubbles, halted=1.
  - Exits only on rst.
- Stall in RUN: fd_wen=0, PC holds; any returned rdata is discarded and refetched.
- Redirect (br_taken=1):
  - Takes priority over fd_stall and over HLT detection.
  - In RUN/BUF: the fetched or buffered word is squashed; bubble with fd_wen=1; PC<=br_target; next state is RUN.
  - In MISS: set redir_pend and redir_tgt<=br_target, and keep waiting. When valid arrives, discard the word, send a bubble, set PC<=redir_tgt, clear redir_pend, go to RUN.
  - A second br_taken while redir_pend=1 overwrites redir_tgt.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000. br_target bit 0 is ignored (forced to 0).

## Timing
- Reset values (rst=1 at an edge): PC=RESET_PC, state=RUN, redir_pend=0, ibuf=0.
- While rst=1: fd_wen=0, halted=0, imem_req=0, fd_instr=NOP_INSTR, fd_oldpc=fd_newpc=RESET_PC.
- Reset mid-miss abandons the miss; the memory must tolerate the dropped request.
- Hit latency: 0 cycles (combinational to F/D inputs); the instruction is in F/D one edge later.
- Miss of N cycles: N bubbles, then the instruction.
- Redirect: exactly one squashed slot in RUN; in MISS, the remaining miss cycles plus one.
- All fd_* outputs are combinational from state, PC, ibuf, and imem inputs. PC, state, ibuf and redirect registers are flopped.

## Structure
- fetch_pkg contains: OPC_HLT=4'hF, NOP_INSTR=16'h0000, PC_INC=16'd2, and the state enum fetch_state_t {RUN, MISS, BUF, HALT}.
- One sub-module, fetch_pc_reg: 16-bit PC flop with write enable and synchronous reset to RESET_PC.
- Next-PC mux, FSM, ibuf and redirect registers live in fetch_stage.

## Test plan
- Reset, then 4 hits with words 0x1111..0x4444: fd_oldpc = 0,2,4,6; fd_newpc = 2,4,6,8; fd_wen=1 every cycle.
- 3-cycle miss at PC=4: imem_addr=4 held for 3 cycles; 3 bubbles; then the instruction with oldpc=4; PC=6 next.
- br_taken with target 0x0040 during the 2nd cycle of a 4-cycle miss at PC=8: imem_addr stays 8 until valid; the word is discarded; the next fetch is at 0x0040.
- fd_stall=1 for 2 cycles when a miss returns 0xABCD: fd_wen=0 for 2 cycles, then fd_instr=0xABCD with the correct PCs; no refetch.
- HLT (0xF000) at PC=0x000A: forwarded once with oldpc=0x000A; halted=1; PC stays 0x000A; bubbles follow. br_taken on the same cycle instead squashes it and halted stays 0.
- PC=0xFFFE hit: fd_newpc=0x0000 and the next imem_addr is 0x0000. Reset asserted mid-miss: PC returns to RESET_PC the following cycle.
